pendulum_episode_return: RTL and testbench



---
 rtl/pendulum_episode_return.sv | 219 +++++++++++++++++++++
 tb/tb_pendulum_episode_return.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pendulum_episode_return.sv
// Episode-return accumulator for the Pendulum reward stream, together with
// the single-precision Adder it launches (AXI-stream-style valid/data ports,
// LATENCY cycles from tvalid to result valid).

module pendulum_adder #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);

  logic [LATENCY-1:0] vld_q;
  logic [31:0]        dat_q [LATENCY];

  // IEEE-754 single add, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, sum;
    logic [24:0] mant_r;
    logic        sticky;
    int          e, d;
    // x always holds the operand of larger magnitude so mx - my never underflows.
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    if (x[30:23] == 8'hFF) return x;
    mx = (x[30:23] == 8'd0) ? 28'd0 : {2'b01, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? 28'd0 : {2'b01, y[22:0], 3'b000};
    if (mx == 28'd0) return 32'd0;
    e = int'(x[30:23]);
    d = e - int'(y[30:23]);
    if (d > 26) begin
      my = {27'd0, |my};
    end else begin
      sticky = |(my & ((28'd1 << d) - 28'd1));
      my     = (my >> d) | {27'd0, sticky};
    end
    sum = (x[31] == y[31]) ? mx + my : mx - my;
    if (sum == 28'd0) return 32'd0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e++;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e--;
        end
      end
    end
    if (e <= 0) return {x[31], 31'd0};
    mant_r = {1'b0, sum[26:3]} + 25'(sum[2] & (sum[3] | sum[1] | sum[0]));
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      e++;
    end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], mant_r[22:0]};
  endfunction

  // Valid pipeline: a result emerges LATENCY cycles after both operands are valid.
  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples the previous value of its neighbour on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= s_axis_a_tvalid & s_axis_b_tvalid;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data pipeline tracks the valid bits.
  // NOTE: the data stages carry no reset; they are only observed when the
  // matching valid bit is set, and leaving them unreset keeps them plain flops.
  always_ff @(posedge clk) begin
    dat_q[0] <= fp_add(s_axis_a_tdata, s_axis_b_tdata);
    for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
  end

  assign m_axis_result_tvalid = vld_q[LATENCY-1];
  assign m_axis_result_tdata  = dat_q[LATENCY-1];

endmodule

module pendulum_episode_return #(
  parameter int RWD_WL    = 32,
  parameter int MAX_STEPS = 200,
  parameter int CNT_WL    = 16,
  parameter int ADD_LAT   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rwd_valid,
  input  logic [RWD_WL-1:0] i_rwd,
  input  logic              i_term,
  input  logic              i_clr,
  output logic              o_ready,
  output logic [RWD_WL-1:0] o_acc,
  output logic [CNT_WL-1:0] o_step_cnt,
  output logic              o_ret_valid,
  output logic [RWD_WL-1:0] o_ret,
  output logic              o_trunc,
  output logic              o_drop
);

  typedef enum logic [1:0] {S_WAIT, S_ADD, S_EMIT, S_FLUSH} state_e;

  state_e              state_q;
  logic [RWD_WL-1:0]   acc_q, ret_q;
  logic [CNT_WL-1:0]   cnt_q;
  logic                ready_q, ret_valid_q, trunc_q, drop_q, term_q;
  logic                accept, add_vld, hit_max;
  logic [RWD_WL-1:0]   add_res;
  logic [CNT_WL-1:0]   cnt_inc;

  // A reward is taken only while the visible ready is high in S_WAIT; clear wins.
  assign accept  = (state_q == S_WAIT) && ready_q && i_rwd_valid && !i_clr;
  assign cnt_inc = cnt_q + 1'b1;
  assign hit_max = (cnt_inc == CNT_WL'(MAX_STEPS));

  pendulum_adder #(.LATENCY(ADD_LAT)) u_adder (
    .clk                  (i_clk),
    .rst_n                (i_rst_n),
    .s_axis_a_tvalid      (accept),
    .s_axis_a_tdata       (acc_q),
    .s_axis_b_tvalid      (accept),
    .s_axis_b_tdata       (i_rwd),
    .m_axis_result_tvalid (add_vld),
    .m_axis_result_tdata  (add_res)
  );

  // Episode FSM; ready and ret_valid are registered and trail the state by a cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_WAIT;
      acc_q       <= '0;
      cnt_q       <= '0;
      ret_q       <= '0;
      ret_valid_q <= 1'b0;
      trunc_q     <= 1'b0;
      drop_q      <= 1'b0;
      ready_q     <= 1'b1;
      term_q      <= 1'b0;
    end else begin
      ret_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      if (i_rwd_valid && !ready_q && !i_clr) drop_q <= 1'b1;
      unique case (state_q)
        S_WAIT: begin
          if (i_clr) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (accept) begin
            term_q  <= i_term;
            state_q <= S_ADD;
          end else begin
            ready_q <= 1'b1;
          end
        end
        // Adder results are honoured only here and in S_FLUSH, so a result
        // left over from before a reset can never touch the accumulator.
        S_ADD: begin
          if (i_clr) begin
            if (add_vld) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              drop_q  <= 1'b0;
              state_q <= S_WAIT;
            end else begin
              state_q <= S_FLUSH;
            end
          end else if (add_vld) begin
            acc_q <= add_res;
            cnt_q <= cnt_inc;
            if (hit_max || term_q) begin
              ret_q   <= add_res;
              trunc_q <= hit_max;
              state_q <= S_EMIT;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_EMIT: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_WAIT;
          if (i_clr) drop_q      <= 1'b0;
          else       ret_valid_q <= 1'b1;
        end
        S_FLUSH: begin
          if (add_vld) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            state_q <= S_WAIT;
          end
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_acc       = acc_q;
  assign o_step_cnt  = cnt_q;
  assign o_ret_valid = ret_valid_q;
  assign o_ret       = ret_q;
  assign o_trunc     = trunc_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_pendulum_episode_return.sv
// Self-checking bench for pendulum_episode_return: a table of episode steps
// plus hand-written latency, clear, drop and reset sequences. Closed episodes
// are predicted into a scoreboard and matched against each o_ret_valid pulse.

module tb_pendulum_episode_return;

  localparam int L    = 3;
  localparam int MAXS = 4;
  localparam int NVEC = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rwd_valid = 1'b0;
  logic [31:0] rwd = '0;
  logic        term = 1'b0;
  logic        clr = 1'b0;
  logic        ready, ret_valid, trunc, drop;
  logic [31:0] acc, ret;
  logic [15:0] cnt;

  typedef struct packed {
    logic [31:0] ret;
    logic        trunc;
  } sb_t;

  typedef struct {
    logic [31:0] rwd;
    logic        term;
    logic [31:0] exp_acc;
    logic [15:0] exp_cnt;
    logic        closes;
    logic [31:0] exp_ret;
    logic        exp_trunc;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[NVEC];
  int   n_checks = 0;
  int   n_errors = 0;

  pendulum_episode_return #(
    .RWD_WL(32), .MAX_STEPS(MAXS), .CNT_WL(16), .ADD_LAT(L)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rwd_valid (rwd_valid),
    .i_rwd       (rwd),
    .i_term      (term),
    .i_clr       (clr),
    .o_ready     (ready),
    .o_acc       (acc),
    .o_step_cnt  (cnt),
    .o_ret_valid (ret_valid),
    .o_ret       (ret),
    .o_trunc     (trunc),
    .o_drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every close pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && ret_valid) begin
      if (sb_q.size() == 0) begin
        check("ret_valid_unexpected", 32'(ret_valid), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_ret", ret, e.ret);
        check("sb_trunc", 32'(trunc), 32'(e.trunc));
      end
    end
  end

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (i == 40) check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  task automatic drive_reward(input logic [31:0] r, input logic t);
    wait_ready("drive");
    rwd_valid = 1'b1;
    rwd       = r;
    term      = t;
    @(negedge clk);
    rwd_valid = 1'b0;
    term      = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},     32'(ready),     32'd1);
    check({tag, "_acc"},       acc,            32'd0);
    check({tag, "_cnt"},       32'(cnt),       32'd0);
    check({tag, "_ret"},       ret,            32'd0);
    check({tag, "_ret_valid"}, 32'(ret_valid), 32'd0);
    check({tag, "_trunc"},     32'(trunc),     32'd0);
    check({tag, "_drop"},      32'(drop),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'hBF000000, 1'b0, 32'hBF000000, 16'd1, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{32'hBF800000, 1'b0, 32'hBFC00000, 16'd2, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{32'hBF800000, 1'b1, 32'h00000000, 16'd0, 1'b1, 32'hC0200000, 1'b0};
    vecs[3]  = '{32'hBF800000, 1'b0, 32'hBF800000, 16'd1, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{32'hBF800000, 1'b0, 32'hC0000000, 16'd2, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{32'hBF800000, 1'b0, 32'hC0400000, 16'd3, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{32'hBF800000, 1'b0, 32'h00000000, 16'd0, 1'b1, 32'hC0800000, 1'b1};
    vecs[7]  = '{32'h3F800000, 1'b0, 32'h3F800000, 16'd1, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{32'h40000000, 1'b1, 32'h00000000, 16'd0, 1'b1, 32'h40400000, 1'b0};
    vecs[9]  = '{32'h3F000000, 1'b0, 32'h3F000000, 16'd1, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{32'h3F000000, 1'b0, 32'h3F800000, 16'd2, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{32'h3F000000, 1'b0, 32'h3FC00000, 16'd3, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{32'h3F000000, 1'b1, 32'h00000000, 16'd0, 1'b1, 32'h40000000, 1'b1};
    vecs[13] = '{32'h40400000, 1'b0, 32'h40400000, 16'd1, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{32'hC0800000, 1'b0, 32'hBF800000, 16'd2, 1'b0, 32'h0,        1'b0};
    vecs[15] = '{32'h3F800000, 1'b0, 32'h00000000, 16'd3, 1'b0, 32'h0,        1'b0};
    vecs[16] = '{32'h3E800000, 1'b0, 32'h00000000, 16'd0, 1'b1, 32'h3E800000, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Table of episode steps.
    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].closes) sb_q.push_back('{ret: vecs[v].exp_ret, trunc: vecs[v].exp_trunc});
      drive_reward(vecs[v].rwd, vecs[v].term);
      wait_ready("vec");
      check($sformatf("vec%0d_acc", v), acc, vecs[v].exp_acc);
      check($sformatf("vec%0d_cnt", v), 32'(cnt), 32'(vecs[v].exp_cnt));
    end

    // Cycle-accurate latency of a non-closing step (accept in cycle T).
    wait_ready("lat");
    rwd_valid = 1'b1; rwd = 32'h3F800000; term = 1'b0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == 1) rwd_valid = 1'b0;
      if (k == L) check("lat_acc_old", acc, 32'h0);
      if (k == L + 1) begin
        check("lat_acc_new", acc, 32'h3F800000);
        check("lat_ready_low", 32'(ready), 32'd0);
      end
      if (k == L + 2) check("lat_ready_high", 32'(ready), 32'd1);
    end

    // Closing step by terminate, same cycle-level view.
    rwd_valid = 1'b1; rwd = 32'h3F800000; term = 1'b1;
    sb_q.push_back('{ret: 32'h40000000, trunc: 1'b0});
    for (int k = 1; k <= L + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin rwd_valid = 1'b0; term = 1'b0; end
      if (k == L + 1) begin
        check("close_pre_valid", 32'(ret_valid), 32'd0);
        check("close_acc", acc, 32'h40000000);
        check("close_cnt", 32'(cnt), 32'd2);
      end
      if (k == L + 2) begin
        check("close_valid", 32'(ret_valid), 32'd1);
        check("close_ready_low", 32'(ready), 32'd0);
        check("close_acc_zero", acc, 32'h0);
      end
      if (k == L + 3) check("close_ready_high", 32'(ready), 32'd1);
    end

    // Clear while the add is in flight.
    drive_reward(32'h3F800000, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_ready("flush");
    check("flush_acc", acc, 32'h0);
    check("flush_cnt", 32'(cnt), 32'd0);

    // Clear in S_EMIT suppresses the close pulse.
    wait_ready("emitclr");
    rwd_valid = 1'b1; rwd = 32'h3F000000; term = 1'b1;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin rwd_valid = 1'b0; term = 1'b0; end
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("emitclr_no_valid", 32'(ret_valid), 32'd0);
    check("emitclr_acc", acc, 32'h0);
    check("emitclr_cnt", 32'(cnt), 32'd0);

    // Dropped reward: sticky flag, counter advances once.
    drive_reward(32'h3F800000, 1'b0);
    rwd_valid = 1'b1; rwd = 32'h40000000;
    @(negedge clk);
    rwd_valid = 1'b0;
    check("drop_set", 32'(drop), 32'd1);
    wait_ready("drop");
    check("drop_cnt", 32'(cnt), 32'd1);
    check("drop_acc", acc, 32'h3F800000);
    drive_reward(32'h3F800000, 1'b0);
    wait_ready("drop2");
    check("drop_sticky", 32'(drop), 32'd1);
    check("drop_cnt2", 32'(cnt), 32'd2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("drop_cleared", 32'(drop), 32'd0);
    check("drop_clr_acc", acc, 32'h0);

    // Asynchronous reset in the middle of an add.
    drive_reward(32'h40000000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 3) @(negedge clk);
    check("postreset_acc", acc, 32'h0);
    check("postreset_cnt", 32'(cnt), 32'd0);
    drive_reward(32'h3F800000, 1'b0);
    wait_ready("postreset");
    check("postreset_new_acc", acc, 32'h3F800000);
    check("postreset_new_cnt", 32'(cnt), 32'd1);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
